// File: rtl/sram_arb_ctrl.sv
// Two-port req/ack arbiter and SETUP/STROBE/HOLD sequencer for an asynchronous SRAM.
// Define SRAM_ARB_RR_EN for round-robin arbitration instead of fixed A>B priority.
module sram_arb_ctrl #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 10,
    parameter int STROBE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  RESETn,
    input  logic                  A_REQ,
    input  logic                  A_WE,
    input  logic [ADDR_WIDTH-1:0] A_ADDR,
    input  logic [DATA_WIDTH-1:0] A_WDATA,
    output logic                  A_ACK,
    output logic [DATA_WIDTH-1:0] A_RDATA,
    input  logic                  B_REQ,
    input  logic                  B_WE,
    input  logic [ADDR_WIDTH-1:0] B_ADDR,
    input  logic [DATA_WIDTH-1:0] B_WDATA,
    output logic                  B_ACK,
    output logic [DATA_WIDTH-1:0] B_RDATA,
    output logic [ADDR_WIDTH-1:0] SRAM_ADDR,
    output logic                  SRAM_CE1n,
    output logic                  SRAM_CE2,
    output logic                  SRAM_OEn,
    output logic                  SRAM_WEn,
    output logic [DATA_WIDTH-1:0] SRAM_DOUT,
    output logic                  SRAM_DOE,
    input  logic [DATA_WIDTH-1:0] SRAM_DIN,
    output logic                  BUSY
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

    localparam logic [3:0] LP_CNT_LOAD = 4'(STROBE_CYCLES - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [3:0]              r_cnt;
    logic                    r_gnt_b;
    logic                    r_we;
    logic                    r_ce1n;
    logic                    r_ce2;
    logic                    r_oen;
    logic                    r_wen;
    logic                    r_doe;
    logic                    r_busy;
    logic                    r_a_ack;
    logic                    r_b_ack;
    logic [ADDR_WIDTH-1:0]   r_sram_addr;
    logic [DATA_WIDTH-1:0]   r_dout;
    logic [DATA_WIDTH-1:0]   r_a_rdata;
    logic [DATA_WIDTH-1:0]   r_b_rdata;

    logic                    w_start;
    logic                    w_pick_b;
    logic                    w_sel_we;
    logic [ADDR_WIDTH-1:0]   w_sel_addr;
    logic [DATA_WIDTH-1:0]   w_sel_wdata;
    logic                    w_last_strobe;

`ifdef SRAM_ARB_RR_EN
    logic r_last_b;

    // On a tie, the port that was not granted last time wins.
    assign w_pick_b = B_REQ && (!A_REQ || !r_last_b);

    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            r_last_b <= 1'b1;
        end else if (w_start) begin
            r_last_b <= w_pick_b;
        end
    end
`else
    assign w_pick_b = !A_REQ;
`endif

    assign w_start       = (r_state == S_IDLE) && (A_REQ || B_REQ);
    assign w_last_strobe = (r_state == S_STROBE) && (r_cnt == 4'd0);
    assign w_sel_we      = w_pick_b ? B_WE    : A_WE;
    assign w_sel_addr    = w_pick_b ? B_ADDR  : A_ADDR;
    assign w_sel_wdata   = w_pick_b ? B_WDATA : A_WDATA;

    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:   if (w_start) w_state_nxt = S_SETUP;
            S_SETUP:  w_state_nxt = S_STROBE;
            S_STROBE: if (r_cnt == 4'd0) w_state_nxt = S_HOLD;
            S_HOLD:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Bus outputs are set one edge ahead so each pin reflects the state it belongs to.
    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            r_cnt       <= '0;
            r_gnt_b     <= 1'b0;
            r_we        <= 1'b0;
            r_ce1n      <= 1'b1;
            r_ce2       <= 1'b0;
            r_oen       <= 1'b1;
            r_wen       <= 1'b1;
            r_doe       <= 1'b0;
            r_busy      <= 1'b0;
            r_a_ack     <= 1'b0;
            r_b_ack     <= 1'b0;
            r_sram_addr <= '0;
            r_dout      <= '0;
            r_a_rdata   <= '0;
            r_b_rdata   <= '0;
        end else begin
            r_a_ack <= 1'b0;
            r_b_ack <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_gnt_b     <= w_pick_b;
                        r_we        <= w_sel_we;
                        r_sram_addr <= w_sel_addr;
                        r_ce1n      <= 1'b0;
                        r_ce2       <= 1'b1;
                        r_busy      <= 1'b1;
                        if (w_sel_we) begin
                            r_doe  <= 1'b1;
                            r_dout <= w_sel_wdata;
                        end
                    end
                end
                S_SETUP: begin
                    r_cnt <= LP_CNT_LOAD;
                    r_oen <= r_we;
                    r_wen <= !r_we;
                end
                S_STROBE: begin
                    if (w_last_strobe) begin
                        r_oen   <= 1'b1;
                        r_wen   <= 1'b1;
                        r_a_ack <= !r_gnt_b;
                        r_b_ack <= r_gnt_b;
                        if (!r_we && !r_gnt_b) r_a_rdata <= SRAM_DIN;
                        if (!r_we &&  r_gnt_b) r_b_rdata <= SRAM_DIN;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_HOLD: begin
                    r_ce1n <= 1'b1;
                    r_ce2  <= 1'b0;
                    r_doe  <= 1'b0;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign A_ACK     = r_a_ack;
    assign A_RDATA   = r_a_rdata;
    assign B_ACK     = r_b_ack;
    assign B_RDATA   = r_b_rdata;
    assign SRAM_ADDR = r_sram_addr;
    assign SRAM_CE1n = r_ce1n;
    assign SRAM_CE2  = r_ce2;
    assign SRAM_OEn  = r_oen;
    assign SRAM_WEn  = r_wen;
    assign SRAM_DOUT = r_dout;
    assign SRAM_DOE  = r_doe;
    assign BUSY      = r_busy;

endmodule

// File: doc/sram_arb_ctrl.md
Name: sram_arb_ctrl

Overview:
- Two-port arbiter and cycle sequencer for one asynchronous SRAM (CE1n/CE2/OEn/WEn style) in the arcade memory subsystem.
- Shares the SRAM between port A (CPU side) and port B (video/DMA side) using a req/ack handshake.
- Turns each granted request into a clocked SETUP/STROBE/HOLD bus cycle.
- Splits the SRAM data bus into DOUT/DOE/DIN; the tristate buffer sits at the top level.

Parameters:
- DATA_WIDTH, 8, SRAM data width.
- ADDR_WIDTH, 10, SRAM address width.
- STROBE_CYCLES, 2, clocks OEn/WEn stay low; legal range 1..15.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- RESETn  in  1  asynchronous, active-low reset.
- A_REQ  in  1  port A request; level, held until A_ACK.
- A_WE  in  1  port A: 1=write, 0=read; stable while A_REQ high.
- A_ADDR  in  ADDR_WIDTH  port A address; stable while A_REQ high.
- A_WDATA  in  DATA_WIDTH  port A write data; stable while A_REQ high.
- A_ACK  out  1  one-cycle completion pulse for port A.
- A_RDATA  out  DATA_WIDTH  port A read data; valid with A_ACK, held until the next port A read completes.
- B_REQ, B_WE, B_ADDR, B_WDATA, B_ACK, B_RDATA: identical to the port A signals, for port B.
- SRAM_ADDR  out  ADDR_WIDTH  SRAM address.
- SRAM_CE1n  out  1  chip enable, active low.
- SRAM_CE2  out  1  chip enable, active high.
- SRAM_OEn  out  1  output enable, active low.
- SRAM_WEn  out  1  write enable, active low.
- SRAM_DOUT  out  DATA_WIDTH  write data driven toward SRAM.
- SRAM_DOE  out  1  data output enable for the top-level tristate.
- SRAM_DIN  in  DATA_WIDTH  data read from SRAM.
- BUSY  out  1  high in every state except IDLE.

Behaviour:
- Reset values (asynchronous): FSM=IDLE, SRAM_CE1n=1, SRAM_CE2=0, SRAM_OEn=1, SRAM_WEn=1, SRAM_DOE=0, SRAM_ADDR=0, SRAM_DOUT=0, A_ACK=B_ACK=0, A_RDATA=B_RDATA=0, BUSY=0, strobe counter=0.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states: IDLE, SETUP, STROBE, HOLD.
- IDLE: chip disabled (CE1n=1, CE2=0).
  - If any REQ is high, arbitrate, latch grant/WE/ADDR/WDATA into internal registers, go to SETUP.
  - Otherwise stay in IDLE.
- Arbitration: fixed priority, A wins when both request.
- SETUP, 1 cycle:
  - CE1n=0, CE2=1, SRAM_ADDR=latched address, OEn=WEn=1.
  - For a write, SRAM_DOE=1 and SRAM_DOUT=latched WDATA.
- STROBE, STROBE_CYCLES cycles:
  - Read: OEn=0.
  - Write: WEn=0, DOE stays 1.
  - Counter loads STROBE_CYCLES-1 on entry and decrements each cycle; exit to HOLD when it reaches 0.
  - Read: SRAM_DIN is captured into the granted port's RDATA register at the end of the last STROBE cycle.
- HOLD, 1 cycle:
  - OEn=WEn=1; CE, ADDR, DOUT and DOE (write) held for address/data hold time.
  - Granted port's ACK=1; next state IDLE.
- Cycle timing: request sampled in IDLE at cycle 0, then SETUP at 1, STROBE at 2..1+S, HOLD/ACK at 2+S.
  - With S=2, ACK is high in cycle 4.
  - Minimum transaction period is 3+S cycles, because IDLE always gives a 1-cycle CE-deasserted turnaround.
- Requester protocol:
  - Drop REQ in the cycle after ACK, or keep it high to issue a new transaction.
  - The controller re-samples REQ in that IDLE cycle.
- REQ dropped before ACK: protocol violation. The cycle still completes and ACK still pulses; no abort.
- Read never drives DOE. OEn and WEn are never low in the same cycle. DOE is never 1 while OEn=0.
- Non-granted port's ACK and RDATA are unchanged.
- Reset asserted mid-transaction: strobes and CE deassert immediately (asynchronous), FSM goes to IDLE, and no ACK is issued for the interrupted transaction.

Optional Feature:
- Macro SRAM_ARB_RR_EN.
- When defined: round-robin arbitration.
  - A last-grant register resets to B, so A wins the first tie.
  - On simultaneous requests, the port not granted last wins.
  - A single requester is always granted.
- When undefined: fixed priority A>B as above; no last-grant register exists.

Test Plan:
- A read: mem[0x012]=0x5A, A_REQ=1, A_WE=0, A_ADDR=0x012, S=2 -> OEn low in cycles 2-3, A_ACK pulse in cycle 4, A_RDATA=0x5A; B_ACK stays 0.
- B write: B_ADDR=0x3FF, B_WDATA=0xC3 -> WEn low in cycles 2-3; DOE=1 in cycles 1-4; DOUT=0xC3; B_ACK in cycle 4; a later A read of 0x3FF returns 0xC3.
- Simultaneous A read and B write, fixed priority -> A served first (ACK cycle 4); B served next (ACK cycle 9).
- Same stimulus with SRAM_ARB_RR_EN and three back-to-back ties -> grant order A, B, A; fixed-priority build with A held high -> B starved, every ACK goes to A.
- RESETn=0 in the second STROBE cycle of a write -> WEn, CE1n and DOE return to reset values in the same cycle; no ACK; target location not written after reset.
- STROBE_CYCLES=1 and 15 -> ACK at cycles 3 and 17 respectively; OEn low for exactly 1 and 15 cycles.
